// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache between MEM and a 256-bit block memory.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_wb #(
  parameter int NUM_LINES = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  data_address_2DC,
  input  logic         read_2DC,
  input  logic         write_2DC,
  input  logic [31:0]  data_write_2DC,
  input  logic [1:0]   data_write_size_2DC,
  input  logic         flush_2DC,
  output logic [31:0]  data_read_fDC,
  output logic         data_valid_fDC,
  output logic         flush_done,
  output logic [31:0]  data_address_2DM,
  output logic         dBlkRead,
  output logic         dBlkWrite,
  output logic [255:0] block_write_2DM,
  input  logic [255:0] block_read_fDM,
  input  logic         block_read_fDM_valid,
  input  logic         block_write_fDM_valid
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int LINE_WORDS = 8;
  localparam int OFFSET_W   = 5;
  localparam int INDEX_W    = $clog2(NUM_LINES);
  localparam int TAG_W      = 32 - OFFSET_W - INDEX_W;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WB         = 3'd1;
  localparam logic [2:0] S_FILL       = 3'd2;
  localparam logic [2:0] S_FLUSH_SCAN = 3'd3;
  localparam logic [2:0] S_FLUSH_WB   = 3'd4;
  localparam logic [2:0] S_FLUSH_DONE = 3'd5;

  localparam logic [INDEX_W-1:0] LAST_LINE = INDEX_W'(NUM_LINES - 1);

  logic [2:0]                  state_reg, state_next;
  logic [NUM_LINES-1:0]        valid_reg, dirty_reg;
  logic [INDEX_W-1:0]          line_cnt_reg;
  logic                        flush_arm_reg;

  logic [TAG_W-1:0]            tag_mem  [NUM_LINES];
  logic [32*LINE_WORDS-1:0]    data_mem [NUM_LINES];

  logic [TAG_W-1:0]            req_tag;
  logic [INDEX_W-1:0]          req_idx, sel_idx;
  logic [2:0]                  word_sel;
  logic [1:0]                  byte_off;
  logic                        req, flushing, hit, is_store;
  logic [TAG_W-1:0]            sel_tag;
  logic [32*LINE_WORDS-1:0]    sel_line, store_line;
  logic [31:0]                 hit_word, merged_word;
  logic [2:0]                  size_n;

  assign req_tag  = data_address_2DC[31 -: TAG_W];
  assign req_idx  = data_address_2DC[OFFSET_W +: INDEX_W];
  assign word_sel = data_address_2DC[4:2];
  assign byte_off = data_address_2DC[1:0];
  assign req      = read_2DC | write_2DC;
  assign is_store = write_2DC;

  assign flushing = (state_reg == S_FLUSH_SCAN) || (state_reg == S_FLUSH_WB) ||
                    (state_reg == S_FLUSH_DONE);
  // During a flush the walk counter owns the array port; otherwise the request index does.
  assign sel_idx  = flushing ? line_cnt_reg : req_idx;
  assign sel_line = data_mem[sel_idx];
  assign sel_tag  = tag_mem[sel_idx];

  assign hit      = (state_reg == S_IDLE) && req && valid_reg[req_idx] && (sel_tag == req_tag);
  assign hit_word = sel_line[{word_sel, 5'b00000} +: 32];
  assign size_n   = (data_write_size_2DC == 2'd0) ? 3'd4 : {1'b0, data_write_size_2DC};

  // Big-endian lanes: the store's most significant byte lands at lane byte_off.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [2:0] rel;
      logic [2:0] shift;
      logic [7:0] lane_byte;
      assign rel       = 3'(gi) - {1'b0, byte_off};
      assign shift     = size_n - 3'd1 - rel;
      assign lane_byte = 8'(data_write_2DC >> {shift, 3'b000});
      assign merged_word[31-8*gi -: 8] = (rel < size_n) ? lane_byte : hit_word[31-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    store_line = sel_line;
    store_line[{word_sel, 5'b00000} +: 32] = merged_word;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          if (!hit)
            state_next = (valid_reg[req_idx] && dirty_reg[req_idx]) ? S_WB : S_FILL;
        end else if (flush_2DC && flush_arm_reg) begin
          state_next = S_FLUSH_SCAN;
        end
      end
      S_WB:         if (block_write_fDM_valid) state_next = S_FILL;
      S_FILL:       if (block_read_fDM_valid) state_next = S_IDLE;
      S_FLUSH_SCAN: begin
        if (dirty_reg[line_cnt_reg])       state_next = S_FLUSH_WB;
        else if (line_cnt_reg == LAST_LINE) state_next = S_FLUSH_DONE;
      end
      S_FLUSH_WB: begin
        if (block_write_fDM_valid)
          state_next = (line_cnt_reg == LAST_LINE) ? S_FLUSH_DONE : S_FLUSH_SCAN;
      end
      S_FLUSH_DONE: state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg     <= S_IDLE;
      valid_reg     <= '0;
      dirty_reg     <= '0;
      line_cnt_reg  <= '0;
      flush_arm_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      // A held flush level must drop for a cycle before it can start another flush.
      if (!flush_2DC) flush_arm_reg <= 1'b1;
      case (state_reg)
        S_IDLE: begin
          if (hit && is_store) dirty_reg[req_idx] <= 1'b1;
          if (!req && flush_2DC && flush_arm_reg) begin
            line_cnt_reg  <= '0;
            flush_arm_reg <= 1'b0;
          end
        end
        S_WB: if (block_write_fDM_valid) dirty_reg[req_idx] <= 1'b0;
        S_FILL: begin
          if (block_read_fDM_valid) begin
            valid_reg[req_idx] <= 1'b1;
            dirty_reg[req_idx] <= 1'b0;
          end
        end
        S_FLUSH_SCAN: begin
          if (!dirty_reg[line_cnt_reg]) begin
            valid_reg[line_cnt_reg] <= 1'b0;
            line_cnt_reg            <= line_cnt_reg + 1'b1;
          end
        end
        S_FLUSH_WB: begin
          if (block_write_fDM_valid) begin
            valid_reg[line_cnt_reg] <= 1'b0;
            dirty_reg[line_cnt_reg] <= 1'b0;
            line_cnt_reg            <= line_cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      if (state_reg == S_FILL && block_read_fDM_valid) begin
        data_mem[req_idx] <= block_read_fDM;
        tag_mem[req_idx]  <= req_tag;
      end else if (hit && is_store) begin
        data_mem[req_idx] <= store_line;
      end
    end
  end

  assign data_valid_fDC  = hit;
  assign data_read_fDC   = hit ? hit_word : 32'h0;
  assign dBlkWrite       = (state_reg == S_WB) || (state_reg == S_FLUSH_WB);
  assign dBlkRead        = (state_reg == S_FILL);
  assign flush_done      = (state_reg == S_FLUSH_DONE);
  assign block_write_2DM = dBlkWrite ? sel_line : '0;

  always_comb begin
    data_address_2DM = 32'h0;
    if (dBlkWrite)     data_address_2DM = {sel_tag, sel_idx, 5'b00000};
    else if (dBlkRead) data_address_2DM = {data_address_2DC[31:5], 5'b00000};
  end

`ifdef DCACHE_STATS_EN
  // filled_reg marks that the next completion is the tail of a miss, not a hit.
  logic filled_reg;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
      filled_reg <= 1'b0;
    end else begin
      if (state_reg == S_FILL && block_read_fDM_valid) filled_reg <= 1'b1;
      else if (hit)                                      filled_reg <= 1'b0;
      if (hit && !filled_reg && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'd1;
      if (state_reg == S_IDLE && (state_next == S_WB || state_next == S_FILL) &&
          miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: cold fill, hit stores, dirty eviction, flush and reset mid-fill.
module tb_dcache_wb;

  logic         clk = 1'b0;
  logic         RESET;
  logic [31:0]  data_address_2DC;
  logic         read_2DC, write_2DC;
  logic [31:0]  data_write_2DC;
  logic [1:0]   data_write_size_2DC;
  logic         flush_2DC;
  logic [31:0]  data_read_fDC;
  logic         data_valid_fDC, flush_done;
  logic [31:0]  data_address_2DM;
  logic         dBlkRead, dBlkWrite;
  logic [255:0] block_write_2DM, block_read_fDM;
  logic         block_read_fDM_valid, block_write_fDM_valid;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_wb #(.NUM_LINES(16)) dut (
    .CLK                   (clk),
    .RESET                 (RESET),
    .data_address_2DC      (data_address_2DC),
    .read_2DC              (read_2DC),
    .write_2DC             (write_2DC),
    .data_write_2DC        (data_write_2DC),
    .data_write_size_2DC   (data_write_size_2DC),
    .flush_2DC             (flush_2DC),
    .data_read_fDC         (data_read_fDC),
    .data_valid_fDC        (data_valid_fDC),
    .flush_done            (flush_done),
    .data_address_2DM      (data_address_2DM),
    .dBlkRead              (dBlkRead),
    .dBlkWrite             (dBlkWrite),
    .block_write_2DM       (block_write_2DM),
    .block_read_fDM        (block_read_fDM),
    .block_read_fDM_valid  (block_read_fDM_valid),
    .block_write_fDM_valid (block_write_fDM_valid)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count             (hit_count),
    .miss_count            (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one request to completion, answering any block transfer in the cycle it appears.
  task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input logic [255:0] fill, output logic [31:0] rdata,
                        output int nrd, output int nwr);
    logic done;
    done = 1'b0;
    nrd = 0;
    nwr = 0;
    rdata = '0;
    data_address_2DC    = addr;
    read_2DC            = rd;
    write_2DC           = wr;
    data_write_size_2DC = size;
    data_write_2DC      = wdata;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      if (data_valid_fDC) begin
        rdata = data_read_fDC;
        done  = 1'b1;
      end else if (dBlkRead) begin
        block_read_fDM       = fill;
        block_read_fDM_valid = 1'b1;
        nrd++;
      end else if (dBlkWrite) begin
        block_write_fDM_valid = 1'b1;
        nwr++;
      end
      tick();
      block_read_fDM_valid  = 1'b0;
      block_write_fDM_valid = 1'b0;
    end
    read_2DC  = 1'b0;
    write_2DC = 1'b0;
    check("access_completes", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] fill_a, fill_b, fill_9, fill_bad;
    logic [31:0]  rdata;
    logic [31:0]  wb_addr [2];
    logic [255:0] wb_blk  [2];
    int nrd, nwr, ndone;

    for (int k = 0; k < 8; k++) begin
      fill_a[32*k +: 32]   = 32'hA0A0_A000 | k;
      fill_9[32*k +: 32]   = 32'h9999_9999;
      fill_bad[32*k +: 32] = 32'h0BAD_C0DE;
    end
    fill_a[63:32] = 32'hDEAD_BEEF;
    fill_b        = '0;
    fill_b[63:32] = 32'h5566_7788;

    RESET = 1'b0;
    data_address_2DC = '0; read_2DC = 1'b0; write_2DC = 1'b0;
    data_write_2DC = '0; data_write_size_2DC = '0; flush_2DC = 1'b0;
    block_read_fDM = '0; block_read_fDM_valid = 1'b0; block_write_fDM_valid = 1'b0;
    repeat (3) tick();
    check("rst_valid", data_valid_fDC, 1'b0);
    check("rst_rd_data", data_read_fDC, 32'h0);
    check("rst_blkread", dBlkRead, 1'b0);
    check("rst_blkwrite", dBlkWrite, 1'b0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_addr_2dm", data_address_2DM, 32'h0);
    RESET = 1'b1;
    tick();

    // Cold read miss with the fill returned three cycles after dBlkRead.
    data_address_2DC = 32'h0000_1004; read_2DC = 1'b1;
    #1 check("t1_miss_valid", data_valid_fDC, 1'b0);
    tick();
    check("t1_blkread", dBlkRead, 1'b1);
    check("t1_fill_addr", data_address_2DM, 32'h0000_1000);
    check("t1_no_blkwrite", dBlkWrite, 1'b0);
    tick(); tick(); tick();
    check("t1_blkread_held", dBlkRead, 1'b1);
    block_read_fDM = fill_a; block_read_fDM_valid = 1'b1;
    tick();
    block_read_fDM_valid = 1'b0;
    #1 check("t1_hit_valid", data_valid_fDC, 1'b1);
    check("t1_hit_data", data_read_fDC, 32'hDEAD_BEEF);
    check("t1_blkread_drop", dBlkRead, 1'b0);
    tick();
    read_2DC = 1'b0;

    // Single-byte store hit, then readback without block traffic.
    data_address_2DC = 32'h0000_1005; write_2DC = 1'b1;
    data_write_size_2DC = 2'd1; data_write_2DC = 32'h0000_00AB;
    #1 check("t2_store_valid", data_valid_fDC, 1'b1);
    tick();
    write_2DC = 1'b0; read_2DC = 1'b1; data_address_2DC = 32'h0000_1004;
    #1 check("t2_read_valid", data_valid_fDC, 1'b1);
    check("t2_read_data", data_read_fDC, 32'hDEAB_BEEF);
    check("t2_no_blkread", dBlkRead, 1'b0);
    check("t2_no_blkwrite", dBlkWrite, 1'b0);
    tick();
    read_2DC = 1'b0;

    // Conflicting tag forces writeback of the dirty line before the fill.
    data_address_2DC = 32'h0000_1204; read_2DC = 1'b1;
    #1 check("t3_miss_valid", data_valid_fDC, 1'b0);
    tick();
    check("t3_blkwrite", dBlkWrite, 1'b1);
    check("t3_wb_no_blkread", dBlkRead, 1'b0);
    check("t3_wb_addr", data_address_2DM, 32'h0000_1000);
    check("t3_wb_word1", block_write_2DM[63:32], 32'hDEAB_BEEF);
    tick();
    check("t3_blkwrite_held", dBlkWrite, 1'b1);
    block_write_fDM_valid = 1'b1;
    tick();
    block_write_fDM_valid = 1'b0;
    #1 check("t3_blkread", dBlkRead, 1'b1);
    check("t3_fill_no_blkwrite", dBlkWrite, 1'b0);
    check("t3_fill_addr", data_address_2DM, 32'h0000_1200);
    block_write_fDM_valid = 1'b1;
    tick();
    block_write_fDM_valid = 1'b0;
    #1 check("t3_stray_valid_ignored", dBlkRead, 1'b1);
    block_read_fDM = fill_b; block_read_fDM_valid = 1'b1;
    tick();
    block_read_fDM_valid = 1'b0;
    #1 check("t3_hit_valid", data_valid_fDC, 1'b1);
    check("t3_hit_data", data_read_fDC, 32'h5566_7788);
    tick();
    read_2DC = 1'b0;
`ifdef DCACHE_STATS_EN
    #1 check("stats_hit_count", hit_count, 32'd2);
    check("stats_miss_count", miss_count, 32'd2);
`endif

    // Dirty lines 1 and 3 with 4-, 2- and 3-byte stores.
    access(32'h0000_1028, 1'b0, 1'b1, 2'd0, 32'hCAFE_F00D, '0, rdata, nrd, nwr);
    check("t4_store4_fills", nrd, 1);
    access(32'h0000_1028, 1'b1, 1'b0, 2'd0, 32'h0, '0, rdata, nrd, nwr);
    check("t4_store4_data", rdata, 32'hCAFE_F00D);
    check("t4_store4_hit", nrd, 0);
    access(32'h0000_1062, 1'b0, 1'b1, 2'd2, 32'h0000_1234, fill_9, rdata, nrd, nwr);
    check("t4_store2_fills", nrd, 1);
    access(32'h0000_1060, 1'b1, 1'b0, 2'd0, 32'h0, '0, rdata, nrd, nwr);
    check("t4_store2_data", rdata, 32'h9999_1234);
    access(32'h0000_1061, 1'b0, 1'b1, 2'd3, 32'h00AB_CDEF, '0, rdata, nrd, nwr);
    access(32'h0000_1060, 1'b1, 1'b0, 2'd0, 32'h0, '0, rdata, nrd, nwr);
    check("t4_store3_data", rdata, 32'h99AB_CDEF);

    // Flush held high throughout, including after flush_done, which must not retrigger.
    flush_2DC = 1'b1;
    nwr = 0;
    ndone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (flush_done) ndone++;
      if (dBlkWrite) begin
        if (nwr < 2) begin
          wb_addr[nwr] = data_address_2DM;
          wb_blk[nwr]  = block_write_2DM;
        end
        nwr++;
        block_write_fDM_valid = 1'b1;
      end
      tick();
      block_write_fDM_valid = 1'b0;
    end
    flush_2DC = 1'b0;
    check("t4_flush_writebacks", nwr, 2);
    check("t4_flush_done_pulses", ndone, 1);
    check("t4_wb0_addr", wb_addr[0], 32'h0000_1020);
    check("t4_wb0_word2", wb_blk[0][95:64], 32'hCAFE_F00D);
    check("t4_wb1_addr", wb_addr[1], 32'h0000_1060);
    check("t4_wb1_word0", wb_blk[1][31:0], 32'h99AB_CDEF);
    tick();
    access(32'h0000_1028, 1'b1, 1'b0, 2'd0, 32'h0, fill_bad, rdata, nrd, nwr);
    check("t4_post_flush_miss_a", nrd, 1);
    check("t4_post_flush_clean_a", nwr, 0);
    check("t4_post_flush_data_a", rdata, 32'h0BAD_C0DE);
    access(32'h0000_1064, 1'b1, 1'b0, 2'd0, 32'h0, fill_bad, rdata, nrd, nwr);
    check("t4_post_flush_miss_b", nrd, 1);

    // Reset while a fill is outstanding.
    data_address_2DC = 32'h0000_1044; read_2DC = 1'b1;
    tick();
    check("t5_blkread", dBlkRead, 1'b1);
    RESET = 1'b0; read_2DC = 1'b0;
    tick();
    check("t5_blkread_drop", dBlkRead, 1'b0);
    check("t5_blkwrite_low", dBlkWrite, 1'b0);
    check("t5_valid_low", data_valid_fDC, 1'b0);
    tick();
    RESET = 1'b1;
    tick();
    access(32'h0000_1028, 1'b1, 1'b0, 2'd0, 32'h0, fill_bad, rdata, nrd, nwr);
    check("t5_post_reset_miss", nrd, 1);
    check("t5_post_reset_data", rdata, 32'h0BAD_C0DE);
    access(32'h0000_1028, 1'b1, 1'b1, 2'd1, 32'h0000_005A, '0, rdata, nrd, nwr);
    check("t5_rdwr_hit", nrd, 0);
    access(32'h0000_1028, 1'b1, 1'b0, 2'd0, 32'h0, '0, rdata, nrd, nwr);
    check("t5_rdwr_is_store", rdata, 32'h5AAD_C0DE);
    access(32'h0000_1044, 1'b1, 1'b0, 2'd0, 32'h0, fill_9, rdata, nrd, nwr);
    check("t5_aborted_line_miss", nrd, 1);
    check("t5_aborted_line_data", rdata, 32'h9999_9999);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
